// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle 32-bit RISC datapath.
// Sequences fetch/decode/execute/memory/writeback and drives all datapath
// mux selects and write enables; stalls on MEM_READY in memory states.
module multicycle_control (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] OPCODE,
    input  logic       MEM_READY,
    output logic       PC_WRITE,
    output logic       PC_WRITE_COND,
    output logic       I_OR_D,
    output logic       MEM_READ,
    output logic       MEM_WRITE,
    output logic       IR_WRITE,
    output logic       MEM_TO_REG,
    output logic       REG_DST,
    output logic       REG_WRITE,
    output logic       ALU_SRC_A,
    output logic [1:0] ALU_SRC_B,
    output logic [1:0] ALU_OP,
    output logic [1:0] PC_SOURCE,
    output logic       ILLEGAL,
    output logic [3:0] STATE
);

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE         = 4'd0,
        S_FETCH        = 4'd1,
        S_DECODE       = 4'd2,
        S_MEM_ADDR     = 4'd3,
        S_MEM_READ_ST  = 4'd4,
        S_MEM_WB       = 4'd5,
        S_MEM_WRITE_ST = 4'd6,
        S_EXECUTE      = 4'd7,
        S_R_WB         = 4'd8,
        S_BRANCH       = 4'd9,
        S_JUMP         = 4'd10,
        S_ADDI_EXEC    = 4'd11,
        S_ADDI_WB      = 4'd12
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [OP_W-1:0] op_q;

    assign STATE = state_q;

    // State register; reset forces IDLE asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode captured in DECODE so later IR changes cannot redirect the FSM.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q <= '0;
        end else if (state_q == S_DECODE) begin
            op_q <= OPCODE;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = MEM_READY ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (OPCODE)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:     state_d = (op_q == OP_LW) ? S_MEM_READ_ST : S_MEM_WRITE_ST;
            S_MEM_READ_ST:  state_d = MEM_READY ? S_MEM_WB : S_MEM_READ_ST;
            S_MEM_WB:       state_d = S_FETCH;
            S_MEM_WRITE_ST: state_d = MEM_READY ? S_FETCH : S_MEM_WRITE_ST;
            S_EXECUTE:      state_d = S_R_WB;
            S_R_WB:         state_d = S_FETCH;
            S_BRANCH:       state_d = S_FETCH;
            S_JUMP:         state_d = S_FETCH;
            S_ADDI_EXEC:    state_d = S_ADDI_WB;
            S_ADDI_WB:      state_d = S_FETCH;
            default:        state_d = S_FETCH;
        endcase
    end

    // Output decode: Moore from state, plus FETCH handshake and DECODE illegal flag.
    always_comb begin
        PC_WRITE      = 1'b0;
        PC_WRITE_COND = 1'b0;
        I_OR_D        = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        IR_WRITE      = 1'b0;
        MEM_TO_REG    = 1'b0;
        REG_DST       = 1'b0;
        REG_WRITE     = 1'b0;
        ALU_SRC_A     = 1'b0;
        ALU_SRC_B     = 2'b00;
        ALU_OP        = 2'b00;
        PC_SOURCE     = 2'b00;
        ILLEGAL       = 1'b0;
        case (state_q)
            S_FETCH: begin
                MEM_READ  = 1'b1;
                ALU_SRC_B = 2'b01;
                IR_WRITE  = MEM_READY;
                PC_WRITE  = MEM_READY;
            end
            S_DECODE: begin
                ALU_SRC_B = 2'b11;
                ILLEGAL   = !(OPCODE inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ALU_SRC_A = 1'b1;
                ALU_SRC_B = 2'b10;
            end
            S_MEM_READ_ST: begin
                MEM_READ = 1'b1;
                I_OR_D   = 1'b1;
            end
            S_MEM_WB: begin
                REG_WRITE  = 1'b1;
                MEM_TO_REG = 1'b1;
            end
            S_MEM_WRITE_ST: begin
                MEM_WRITE = 1'b1;
                I_OR_D    = 1'b1;
            end
            S_EXECUTE: begin
                ALU_SRC_A = 1'b1;
                ALU_OP    = 2'b10;
            end
            S_R_WB: begin
                REG_WRITE = 1'b1;
                REG_DST   = 1'b1;
            end
            S_BRANCH: begin
                ALU_SRC_A     = 1'b1;
                ALU_OP        = 2'b01;
                PC_WRITE_COND = 1'b1;
                PC_SOURCE     = 2'b01;
            end
            S_JUMP: begin
                PC_WRITE  = 1'b1;
                PC_SOURCE = 2'b10;
            end
            S_ADDI_WB: begin
                REG_WRITE = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
